axis_dest_tagger: RTL and testbench
===================================

# axis_dest_tagger

Frame classifier placed directly upstream of `axis_switch`. It decodes a selector field from the first beat of each AXI-Stream frame and maps it through a constant table to `tdest`. That `tdest` is held on every beat of the frame. Frames longer than `MAX_LEN` beats are truncated: a forced `tlast` with the error bit set in `tuser`, then the remainder is discarded. The result is that the switch always sees per-frame-constant `tdest` and bounded frame length.

## Interface
- `DATA_WIDTH`, 8: `tdata` width.
- `KEEP_WIDTH`, `DATA_WIDTH/8`: `tkeep` width.
- `ID_WIDTH`, 8: `tid` width.
- `DEST_WIDTH`, 3: output `tdest` width.
- `USER_WIDTH`, 1: `tuser` width; bit 0 is the frame error flag.
- `SEL_OFFSET`, 0: LSB position of the selector field in head-beat `tdata`.
- `SEL_WIDTH`, 2: selector width. `SEL_OFFSET+SEL_WIDTH <= DATA_WIDTH`.
- `DEST_MAP`, `{3'd3,3'd2,3'd1,3'd0}`: `2**SEL_WIDTH` concatenated `DEST_WIDTH` constants. Entry i is the `tdest` for selector value i.
- `MAX_LEN`, 1518: maximum beats per frame, >= 2.
- `LEN_WIDTH`, 16: beat counter width. `MAX_LEN < 2**LEN_WIDTH`.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `s_axis_tdata/tkeep/tvalid/tready/tlast/tid/tuser`  in (`tready` out)  `DATA_WIDTH`/`KEEP_WIDTH`/1/1/1/`ID_WIDTH`/`USER_WIDTH`  input stream, no `tdest`.
- `m_axis_tdata/tkeep/tvalid/tready/tlast/tid/tdest/tuser`  out (`tready` in)  same widths, plus `DEST_WIDTH`  tagged output stream.
- `stat_frames`  out  32  count of frames emitted, including truncated frames; wraps modulo 2^32.
- `stat_truncated`  out  1  one-cycle pulse per truncated frame.

## Operation
- States: HEAD (next accepted beat is a frame head), BODY, DROP.
- Input acceptance is accept = `s_axis_tvalid && s_axis_tready`.
- HEAD, on accept:
  - sel = `tdata[SEL_OFFSET +: SEL_WIDTH]`; dest = `DEST_MAP[sel*DEST_WIDTH +: DEST_WIDTH]`.
  - Latch `dest_reg`.
  - Emit the beat with `tdest` = dest.
  - `beat_cnt` <= 1.
  - If `tlast`: stay in HEAD. Else: go to BODY.
- BODY, on accept:
  - Emit the beat with `tdest` = `dest_reg`; `beat_cnt` increments.
  - If `tlast`: go to HEAD.
  - Else if this is beat number `MAX_LEN`: emit with `tlast`=1 and `tuser[0]`=1 (other `tuser` bits pass through), pulse `stat_truncated`, go to DROP.
- DROP: `s_axis_tready`=1 and nothing is emitted. The accepted beat with `tlast` returns the block to HEAD; that beat is also discarded.
- A head beat that is also `tlast` is a valid 1-beat frame.
- A natural `tlast` on beat `MAX_LEN` is not a truncation.
- `stat_frames` increments when any emitted beat with `tlast`=1 (natural or forced) is loaded into the output register.
- `tdata`, `tkeep`, `tid` and `tuser` pass through unmodified, except for `tuser[0]` on truncation.
- Every selector value is mapped; there is no drop-by-selector.

## Timing
- Output stage is one register; latency is 1 cycle from input accept to `m_axis_tvalid`.
- `s_axis_tready` = DROP ? 1 : (`!m_axis_tvalid || m_axis_tready`). This gives full throughput of 1 beat per cycle with no bubbles between frames.
- Output register loads on every non-DROP accept. It clears `m_axis_tvalid` when `m_axis_tready` is high and there is no new load.
- While `m_axis_tvalid && !m_axis_tready`, all `m_axis_*` are stable.
- Reset values:
  - state = HEAD.
  - `m_axis_tvalid`=0.
  - `m_axis_tdata/tkeep/tlast/tid/tdest/tuser`=0.
  - `dest_reg`=0, `beat_cnt`=0.
  - `stat_frames`=0, `stat_truncated`=0.
- Reset mid-frame drops the in-flight output beat. The next accepted beat is decoded as a new head.
- Simultaneous downstream take and new load in the same cycle: the register is replaced with no gap.

## Structure
- Shared package holds the state enum (HEAD, BODY, DROP) and the `TUSER_ERR_BIT` = 0 constant.
- Single module. The output register is inline, with no sub-module, because its ready path must see the DROP state.

## Test plan
- Single-beat frame: `DEST_MAP={3'd4,3'd5,3'd6,3'd7}`, `tdata`=0x02, `tlast`=1 -> one output beat, `tdest`=5, `tlast`=1, `stat_frames`=1.
- 3-beat frame: head `tdata`=0x01, body `tdata`=0x03 and 0x00 -> all three beats have `tdest`=6 (the body selector bits are ignored).
- Backpressure: `m_axis_tready`=0 for 3 cycles mid-frame -> `s_axis_tready`=0 after the register fills, output is held stable, and no beat is lost or duplicated.
- Truncation, `MAX_LEN`=4, 6-beat frame:
  - Output is 4 beats; beat 4 has `tlast`=1 and `tuser`=1.
  - Beats 5-6 are accepted with no output.
  - One `stat_truncated` pulse.
  - A following frame decodes normally.
- Reset mid-frame: after 2 body beats, assert `rst` for 1 cycle -> `m_axis_tvalid`=0, counters are 0, and the next beat, `tdata`=0x03, gets `tdest`=4.
- Back-to-back 1-beat frames with `tdata` 0,1,2,3 and `m_axis_tready`=1 -> 4 outputs on consecutive cycles with `tdest` 7,6,5,4.

Source files
------------

// File: rtl/axis_dest_tagger_pkg.sv
// Shared types and constants for the AXI-Stream destination tagger.
package axis_dest_tagger_pkg;

  typedef enum logic [1:0] {
    HEAD = 2'd0,
    BODY = 2'd1,
    DROP = 2'd2
  } state_t;

  localparam int unsigned TUSER_ERR_BIT = 0;

endpackage

// File: rtl/axis_dest_tagger.sv
// Tags each AXI-Stream frame with a tdest decoded from its head beat and
// truncates frames longer than MAX_LEN beats, flagging them in tuser.
module axis_dest_tagger
  import axis_dest_tagger_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int unsigned ID_WIDTH   = 8,
  parameter int unsigned DEST_WIDTH = 3,
  parameter int unsigned USER_WIDTH = 1,
  parameter int unsigned SEL_OFFSET = 0,
  parameter int unsigned SEL_WIDTH  = 2,
  parameter logic [(2**SEL_WIDTH)*DEST_WIDTH-1:0] DEST_MAP = {3'd3, 3'd2, 3'd1, 3'd0},
  parameter int unsigned MAX_LEN    = 1518,
  parameter int unsigned LEN_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  input  logic [ID_WIDTH-1:0]   s_axis_tid,
  input  logic [USER_WIDTH-1:0] s_axis_tuser,

  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic [ID_WIDTH-1:0]   m_axis_tid,
  output logic [DEST_WIDTH-1:0] m_axis_tdest,
  output logic [USER_WIDTH-1:0] m_axis_tuser,

  output logic [31:0]           stat_frames,
  output logic                  stat_truncated
);

  localparam int unsigned NUM_SEL = 1 << SEL_WIDTH;

  state_t                state_q, state_d;
  logic [DEST_WIDTH-1:0] dest_reg, dest_d;
  logic [LEN_WIDTH-1:0]  beat_cnt, cnt_d, cnt_inc;

  logic                  accept_c;
  logic                  load_c;
  logic                  trunc_c;
  logic [DEST_WIDTH-1:0] out_dest_c;
  logic                  out_last_c;
  logic [USER_WIDTH-1:0] out_user_c;
  logic [SEL_WIDTH-1:0]  sel_c;
  logic [DEST_WIDTH-1:0] head_dest_c;
  logic [DEST_WIDTH-1:0] dest_tbl [NUM_SEL];

  // Unpack the flat selector->tdest map into a lookup table
  for (genvar i = 0; i < NUM_SEL; i++) begin : g_map
    assign dest_tbl[i] = DEST_MAP[i*DEST_WIDTH +: DEST_WIDTH];
  end

  assign sel_c       = s_axis_tdata[SEL_OFFSET +: SEL_WIDTH];
  assign head_dest_c = dest_tbl[sel_c];
  assign cnt_inc     = beat_cnt + LEN_WIDTH'(1);

  // DROP swallows beats regardless of the output register
  assign s_axis_tready = (state_q == DROP) || !m_axis_tvalid || m_axis_tready;
  assign accept_c      = s_axis_tvalid && s_axis_tready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= HEAD;
      dest_reg <= '0;
      beat_cnt <= '0;
    end else begin
      state_q  <= state_d;
      dest_reg <= dest_d;
      beat_cnt <= cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    dest_d     = dest_reg;
    cnt_d      = beat_cnt;
    load_c     = 1'b0;
    trunc_c    = 1'b0;
    out_dest_c = dest_reg;
    out_last_c = s_axis_tlast;
    out_user_c = s_axis_tuser;
    if (accept_c) begin
      unique case (state_q)
        HEAD: begin
          load_c     = 1'b1;
          dest_d     = head_dest_c;
          out_dest_c = head_dest_c;
          cnt_d      = LEN_WIDTH'(1);
          state_d    = s_axis_tlast ? HEAD : BODY;
        end
        BODY: begin
          load_c = 1'b1;
          cnt_d  = cnt_inc;
          if (s_axis_tlast) begin
            state_d = HEAD;
          end else if (cnt_inc == LEN_WIDTH'(MAX_LEN)) begin
            // Frame hit its length limit: close it with an error and discard the rest
            out_last_c                = 1'b1;
            out_user_c[TUSER_ERR_BIT] = 1'b1;
            trunc_c                   = 1'b1;
            state_d                   = DROP;
          end
        end
        DROP: begin
          if (s_axis_tlast) state_d = HEAD;
        end
        default: state_d = HEAD;
      endcase
    end
  end

  // Single output register stage plus statistics
  always_ff @(posedge clk) begin
    if (rst) begin
      m_axis_tvalid  <= 1'b0;
      m_axis_tdata   <= '0;
      m_axis_tkeep   <= '0;
      m_axis_tlast   <= 1'b0;
      m_axis_tid     <= '0;
      m_axis_tdest   <= '0;
      m_axis_tuser   <= '0;
      stat_frames    <= '0;
      stat_truncated <= 1'b0;
    end else begin
      stat_truncated <= trunc_c;
      if (load_c) begin
        m_axis_tvalid <= 1'b1;
        m_axis_tdata  <= s_axis_tdata;
        m_axis_tkeep  <= s_axis_tkeep;
        m_axis_tlast  <= out_last_c;
        m_axis_tid    <= s_axis_tid;
        m_axis_tdest  <= out_dest_c;
        m_axis_tuser  <= out_user_c;
        if (out_last_c) stat_frames <= stat_frames + 32'd1;
      end else if (m_axis_tready) begin
        m_axis_tvalid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_axis_dest_tagger.sv
// Self-checking bench for axis_dest_tagger: directed vector table, backpressure,
// randomized traffic against a frame-level reference model, and mid-frame reset.
module tb_axis_dest_tagger;

  localparam int unsigned MAXL = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] s_data;
  logic [0:0] s_keep;
  logic       s_valid;
  logic       s_ready;
  logic       s_last;
  logic [7:0] s_id;
  logic [0:0] s_user;
  logic [7:0] m_data;
  logic [0:0] m_keep;
  logic       m_valid;
  logic       m_ready;
  logic       m_last;
  logic [7:0] m_id;
  logic [2:0] m_dest;
  logic [0:0] m_user;
  logic [31:0] stat_frames;
  logic       stat_trunc;

  always #5 clk = ~clk;

  axis_dest_tagger #(
    .DEST_MAP ({3'd4, 3'd5, 3'd6, 3'd7}),
    .MAX_LEN  (MAXL)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .s_axis_tdata   (s_data),
    .s_axis_tkeep   (s_keep),
    .s_axis_tvalid  (s_valid),
    .s_axis_tready  (s_ready),
    .s_axis_tlast   (s_last),
    .s_axis_tid     (s_id),
    .s_axis_tuser   (s_user),
    .m_axis_tdata   (m_data),
    .m_axis_tkeep   (m_keep),
    .m_axis_tvalid  (m_valid),
    .m_axis_tready  (m_ready),
    .m_axis_tlast   (m_last),
    .m_axis_tid     (m_id),
    .m_axis_tdest   (m_dest),
    .m_axis_tuser   (m_user),
    .stat_frames    (stat_frames),
    .stat_truncated (stat_trunc)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int exp_frames = 0;

  // Selector -> tdest for the map {4,5,6,7}
  int tb_map [4] = '{7, 6, 5, 4};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  typedef struct {
    logic [7:0] data;
    logic       last;
    logic       user;
    logic       ev;
    logic [2:0] ed;
    logic       el;
    logic       eu;
    logic       et;
  } vec_t;

  vec_t vt[$];

  task automatic add(input logic [7:0] d, input logic l, input logic u, input logic ev,
                     input logic [2:0] ed, input logic el, input logic eu, input logic et);
    vec_t v;
    v.data = d; v.last = l; v.user = u; v.ev = ev; v.ed = ed; v.el = el; v.eu = eu; v.et = et;
    vt.push_back(v);
  endtask

  typedef struct {
    logic [7:0] d;
    logic       k;
    logic [7:0] id;
    logic       u;
    logic       l;
    logic [2:0] dest;
  } beat_t;

  beat_t in_q[$];
  beat_t out_q[$];
  beat_t exp_q[$];
  logic  mon_en = 1'b0;
  logic  rand_on = 1'b0;
  int    trunc_seen = 0;
  logic  prev_stall = 1'b0;
  logic [31:0] prev_bus = '0;

  function automatic logic [31:0] pack_beat(input beat_t b);
    return {9'd0, b.d, b.k, b.id, b.u, b.l, b.dest};
  endfunction

  // Monitor: handshakes and hold-stability, sampled away from the active edge
  always @(negedge clk) begin
    if (mon_en) begin
      beat_t b;
      logic [31:0] bus;
      bus = {9'd0, m_data, m_keep, m_id, m_user, m_last, m_dest, m_valid};
      if (prev_stall) chk("hold_stable", bus, prev_bus);
      prev_stall = m_valid && !m_ready;
      prev_bus   = bus;
      if (s_valid && s_ready) begin
        b.d = s_data; b.k = s_keep[0]; b.id = s_id; b.u = s_user[0]; b.l = s_last; b.dest = 3'd0;
        in_q.push_back(b);
      end
      if (m_valid && m_ready) begin
        b.d = m_data; b.k = m_keep[0]; b.id = m_id; b.u = m_user[0]; b.l = m_last; b.dest = m_dest;
        out_q.push_back(b);
      end
      if (stat_trunc) trunc_seen++;
    end
  end

  // Frame-level reference: dest from the head selector, cap at MAXL beats
  function automatic int build_expected();
    int ntr = 0;
    int i = 0;
    exp_q.delete();
    while (i < in_q.size()) begin
      int s = i;
      int n;
      logic [1:0] sel;
      while (i < in_q.size() && !in_q[i].l) i++;
      n = (i < in_q.size()) ? (i - s + 1) : (i - s);
      sel = in_q[s].d[1:0];
      for (int k = 0; k < n && k < int'(MAXL); k++) begin
        beat_t b = in_q[s + k];
        b.dest = 3'(tb_map[sel]);
        if (n > int'(MAXL) && k == int'(MAXL) - 1) begin
          b.l = 1'b1;
          b.u = 1'b1;
          ntr++;
        end
        exp_q.push_back(b);
      end
      i = s + n;
    end
    return ntr;
  endfunction

  initial begin
    int ntr;
    int nmin;
    int budget;
    logic acc;
    bit timed_out;

    rst = 1'b1; s_valid = 1'b0; s_data = '0; s_keep = '0; s_last = 1'b0;
    s_id = '0; s_user = '0; m_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 32'(m_valid), 32'd0);
    chk("rst_data", 32'(m_data), 32'd0);
    chk("rst_dest", 32'(m_dest), 32'd0);
    chk("rst_last", 32'(m_last), 32'd0);
    chk("rst_frames", stat_frames, 32'd0);
    chk("rst_trunc", 32'(stat_trunc), 32'd0);
    chk("rst_s_ready", 32'(s_ready), 32'd1);
    rst = 1'b0;

    // data, last, user -> valid, dest, last, user, trunc pulse
    add(8'h02, 1, 0, 1, 3'd5, 1, 0, 0);
    add(8'h01, 0, 0, 1, 3'd6, 0, 0, 0);
    add(8'h03, 0, 0, 1, 3'd6, 0, 0, 0);
    add(8'h00, 1, 0, 1, 3'd6, 1, 0, 0);
    add(8'h00, 1, 0, 1, 3'd7, 1, 0, 0);
    add(8'h01, 1, 0, 1, 3'd6, 1, 0, 0);
    add(8'h02, 1, 0, 1, 3'd5, 1, 0, 0);
    add(8'h03, 1, 0, 1, 3'd4, 1, 0, 0);
    add(8'h03, 0, 0, 1, 3'd4, 0, 0, 0);
    add(8'h11, 0, 0, 1, 3'd4, 0, 0, 0);
    add(8'h12, 0, 0, 1, 3'd4, 0, 0, 0);
    add(8'h13, 0, 0, 1, 3'd4, 1, 1, 1);
    add(8'h14, 0, 0, 0, 3'd0, 0, 0, 0);
    add(8'h15, 1, 0, 0, 3'd0, 0, 0, 0);
    add(8'h00, 1, 0, 1, 3'd7, 1, 0, 0);
    add(8'h02, 0, 1, 1, 3'd5, 0, 1, 0);
    add(8'h01, 0, 0, 1, 3'd5, 0, 0, 0);
    add(8'h02, 0, 0, 1, 3'd5, 0, 0, 0);
    add(8'h03, 1, 0, 1, 3'd5, 1, 0, 0);

    m_ready = 1'b1;
    foreach (vt[i]) begin
      s_valid = 1'b1; s_data = vt[i].data; s_last = vt[i].last; s_user = vt[i].user;
      s_id = 8'(i + 8'h40); s_keep = 1'b1;
      @(posedge clk);
      #1;
      chk("tbl_valid", 32'(m_valid), 32'(vt[i].ev));
      if (vt[i].ev) begin
        chk("tbl_data", 32'(m_data), 32'(vt[i].data));
        chk("tbl_id", 32'(m_id), 32'(i + 8'h40));
        chk("tbl_dest", 32'(m_dest), 32'(vt[i].ed));
        chk("tbl_last", 32'(m_last), 32'(vt[i].el));
        chk("tbl_user", 32'(m_user), 32'(vt[i].eu));
        if (vt[i].el) exp_frames++;
      end
      chk("tbl_trunc", 32'(stat_trunc), 32'(vt[i].et));
      chk("tbl_frames", stat_frames, 32'(exp_frames));
    end
    s_valid = 1'b0; s_last = 1'b0; s_user = '0;
    @(posedge clk);
    #1;

    // Backpressure mid-frame: head held in the output, body beat waits upstream
    m_ready = 1'b0;
    s_valid = 1'b1; s_data = 8'h01; s_last = 1'b0; s_id = 8'hA0;
    @(posedge clk);
    #1;
    chk("bp_valid", 32'(m_valid), 32'd1);
    chk("bp_s_ready", 32'(s_ready), 32'd0);
    s_data = 8'h03; s_id = 8'hA1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      chk("bp_hold_data", 32'(m_data), 32'h01);
      chk("bp_hold_dest", 32'(m_dest), 32'd6);
      chk("bp_hold_s_ready", 32'(s_ready), 32'd0);
    end
    m_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_b_data", 32'(m_data), 32'h03);
    chk("bp_b_dest", 32'(m_dest), 32'd6);
    s_data = 8'h00; s_id = 8'hA2; s_last = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_c_data", 32'(m_data), 32'h00);
    chk("bp_c_last", 32'(m_last), 32'd1);
    exp_frames++;
    s_valid = 1'b0; s_last = 1'b0;
    @(posedge clk);
    #1;
    chk("bp_drained", 32'(m_valid), 32'd0);
    chk("bp_frames", stat_frames, 32'(exp_frames));

    // Randomized traffic with random upstream/downstream stalls
    in_q.delete(); out_q.delete(); trunc_seen = 0; prev_stall = 1'b0;
    mon_en = 1'b1;
    rand_on = 1'b1;
    timed_out = 1'b0;
    fork
      begin
        while (rand_on) begin
          @(posedge clk);
          #1;
          m_ready = ($urandom % 3) != 0;
        end
      end
    join_none
    for (int f = 0; f < 60 && !timed_out; f++) begin
      int len = $urandom_range(1, 7);
      for (int b = 0; b < len && !timed_out; b++) begin
        s_data = 8'($urandom); s_keep = 1'($urandom); s_id = 8'($urandom);
        s_user = 1'($urandom); s_last = (b == len - 1);
        acc = 1'b0;
        budget = 0;
        while (!acc) begin
          s_valid = ($urandom % 4) != 0;
          @(negedge clk);
          acc = s_valid && s_ready;
          @(posedge clk);
          #1;
          budget++;
          if (budget > 200) begin
            chk("rnd_timeout", 32'(acc), 32'd1);
            timed_out = 1'b1;
            acc = 1'b1;
          end
        end
      end
      s_valid = 1'b0;
      if (($urandom % 3) == 0) begin
        @(posedge clk);
        #1;
      end
    end
    s_valid = 1'b0; s_last = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
    end
    rand_on = 1'b0;
    @(posedge clk);
    #2;
    m_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    mon_en = 1'b0;

    ntr = build_expected();
    chk("rnd_count", 32'(out_q.size()), 32'(exp_q.size()));
    nmin = (out_q.size() < exp_q.size()) ? out_q.size() : exp_q.size();
    for (int i = 0; i < nmin; i++) begin
      if (pack_beat(out_q[i]) !== pack_beat(exp_q[i]))
        $display("FAIL rnd_beat[%0d]: got 0x%0h expected 0x%0h", i,
                 pack_beat(out_q[i]), pack_beat(exp_q[i]));
      n_checks++;
      if (pack_beat(out_q[i]) === pack_beat(exp_q[i])) n_pass++;
    end
    chk("rnd_trunc", 32'(trunc_seen), 32'(ntr));
    foreach (exp_q[i]) if (exp_q[i].l) exp_frames++;
    chk("rnd_frames", stat_frames, 32'(exp_frames));

    // Reset mid-frame: head plus two body beats, then reset for one cycle
    m_ready = 1'b1;
    s_valid = 1'b1; s_data = 8'h01; s_last = 1'b0; s_user = '0; s_keep = 1'b1; s_id = 8'h10;
    @(posedge clk);
    #1;
    s_data = 8'h00;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    chk("rm_pre_valid", 32'(m_valid), 32'd1);
    s_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rm_valid", 32'(m_valid), 32'd0);
    chk("rm_frames", stat_frames, 32'd0);
    chk("rm_dest", 32'(m_dest), 32'd0);
    s_valid = 1'b1; s_data = 8'h03; s_last = 1'b1;
    @(posedge clk);
    #1;
    chk("rm_new_valid", 32'(m_valid), 32'd1);
    chk("rm_new_dest", 32'(m_dest), 32'd4);
    chk("rm_new_last", 32'(m_last), 32'd1);
    chk("rm_new_frames", stat_frames, 32'd1);
    s_valid = 1'b0; s_last = 1'b0;
    @(posedge clk);
    #1;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
